// File: rtl/hk_spi_param.sv
// rtl/hk_spi_param.sv - housekeeping SPI slave: command/address/data framing, register strobes
// and per-channel flash pass-through select. Rising SCK samples, falling SCK drives.
module hk_spi_param #(
  parameter int AW    = 8,
  parameter int DW    = 8,
  parameter int NPASS = 2
) (
  input  logic             SCK,
  input  logic             csb_reset,
  input  logic             SDI,
  output logic             SDO,
  output logic             sdoenb,
  input  logic [DW-1:0]    idata,
  output logic [DW-1:0]    odata,
  output logic [AW-1:0]    oaddr,
  output logic             rdstb,
  output logic             wrstb,
  output logic [NPASS-1:0] pass_thru,
  output logic [NPASS-1:0] pass_thru_reset
);

  localparam int MAXW = (AW > DW) ? ((AW > 8) ? AW : 8) : ((DW > 8) ? DW : 8);
  localparam int CW   = $clog2(MAXW);

  typedef enum logic [1:0] {
    S_COMMAND = 2'd0,
    S_ADDRESS = 2'd1,
    S_DATA    = 2'd2,
    S_PASS    = 2'd3
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_count;
  logic [AW-1:0]    r_addr;
  logic [DW-2:0]    r_predata;
  logic [DW-1:0]    r_ldata;
  logic             r_write;
  logic             r_read;
  logic [2:0]       r_nnn;
  logic [1:0]       r_psel;
  logic             r_rdstb;
  logic             r_wrstb;
  logic             r_sdoenb;
  logic [NPASS-1:0] r_pass_thru;
  logic [NPASS-1:0] r_pass_thru_reset;

  logic [2:0]       w_psel;
  logic [NPASS-1:0] w_pass_mask;
  logic             w_pass_hit;

  // The last psel bit is still on SDI when the command completes.
  assign w_psel = {r_psel, SDI};

  always_comb begin
    w_pass_mask = '0;
    for (int i = 0; i < NPASS; i++) begin
      w_pass_mask[i] = (w_psel == 3'(i + 1));
    end
  end

  assign w_pass_hit = |w_pass_mask;

  always_ff @(posedge SCK or posedge csb_reset) begin
    if (csb_reset) begin
      r_state           <= S_COMMAND;
      r_count           <= '0;
      r_addr            <= '0;
      r_predata         <= '0;
      r_write           <= 1'b0;
      r_read            <= 1'b0;
      r_nnn             <= 3'd0;
      r_psel            <= 2'd0;
      r_rdstb           <= 1'b0;
      r_pass_thru       <= '0;
      r_pass_thru_reset <= '0;
    end else begin
      case (r_state)
        S_COMMAND: begin
          r_rdstb <= 1'b0;
          r_count <= r_count + 1'b1;
          if (r_count == CW'(0)) begin
            r_write <= SDI;
          end else if (r_count == CW'(1)) begin
            r_read <= SDI;
          end else if (r_count < CW'(5)) begin
            r_nnn <= {r_nnn[1:0], SDI};
          end else if (r_count < CW'(7)) begin
            r_psel <= {r_psel[0], SDI};
          end else begin
            r_count <= '0;
            if (w_pass_hit) begin
              r_state           <= S_PASS;
              r_pass_thru_reset <= w_pass_mask;
            end else begin
              r_state <= S_ADDRESS;
            end
          end
        end

        S_ADDRESS: begin
          r_addr <= {r_addr[AW-2:0], SDI};
          if (r_count == CW'(AW - 1)) begin
            r_count <= '0;
            r_state <= S_DATA;
            r_rdstb <= r_read;
          end else begin
            r_count <= r_count + 1'b1;
            r_rdstb <= 1'b0;
          end
        end

        S_DATA: begin
          r_predata <= {r_predata[DW-3:0], SDI};
          if (r_count == CW'(DW - 1)) begin
            r_count <= '0;
            r_rdstb <= r_read;
            // nnn counts remaining words; zero means stream until CSB.
            if (r_nnn == 3'd1) begin
              r_state <= S_COMMAND;
            end else begin
              r_addr <= r_addr + 1'b1;
              if (r_nnn != 3'd0) begin
                r_nnn <= r_nnn - 1'b1;
              end
            end
          end else begin
            r_count <= r_count + 1'b1;
            r_rdstb <= 1'b0;
          end
        end

        default: begin
          r_rdstb     <= 1'b0;
          r_pass_thru <= r_pass_thru_reset;
        end
      endcase
    end
  end

  // Falling-edge side: readback shifter, output enable and write strobe.
  always_ff @(negedge SCK or posedge csb_reset) begin
    if (csb_reset) begin
      r_ldata  <= '0;
      r_sdoenb <= 1'b1;
      r_wrstb  <= 1'b0;
    end else begin
      case (r_state)
        S_DATA: begin
          if (r_read) begin
            r_sdoenb <= 1'b0;
            if (r_count == CW'(0)) begin
              r_ldata <= idata;
            end else begin
              r_ldata <= {r_ldata[DW-2:0], 1'b0};
            end
          end else begin
            r_sdoenb <= 1'b1;
          end
          r_wrstb <= r_write && (r_count == CW'(DW - 1));
        end

        S_PASS: begin
          r_sdoenb <= 1'b0;
          r_wrstb  <= 1'b0;
        end

        default: begin
          r_sdoenb <= 1'b1;
          r_wrstb  <= 1'b0;
        end
      endcase
    end
  end

  assign SDO             = r_ldata[DW-1];
  assign sdoenb          = r_sdoenb;
  assign odata           = {r_predata, SDI};
  assign oaddr           = (r_state == S_ADDRESS) ? {r_addr[AW-2:0], SDI} : r_addr;
  assign rdstb           = r_rdstb;
  assign wrstb           = r_wrstb;
  assign pass_thru       = r_pass_thru;
  assign pass_thru_reset = r_pass_thru_reset;

endmodule

// File: tb/tb_hk_spi_param.sv
// tb/tb_hk_spi_param.sv - scoreboard bench for hk_spi_param: SPI master stimulus,
// register-file model and a monitor that checks strobes and SDO against queued expectations.
module tb_hk_spi_param;

  localparam int AW    = 8;
  localparam int DW    = 16;
  localparam int NPASS = 2;

  logic             SCK;
  logic             csb_reset;
  logic             SDI;
  logic             SDO;
  logic             sdoenb;
  logic [DW-1:0]    idata;
  logic [DW-1:0]    odata;
  logic [AW-1:0]    oaddr;
  logic             rdstb;
  logic             wrstb;
  logic [NPASS-1:0] pass_thru;
  logic [NPASS-1:0] pass_thru_reset;

  hk_spi_param #(.AW(AW), .DW(DW), .NPASS(NPASS)) dut (
    .SCK             (SCK),
    .csb_reset       (csb_reset),
    .SDI             (SDI),
    .SDO             (SDO),
    .sdoenb          (sdoenb),
    .idata           (idata),
    .odata           (odata),
    .oaddr           (oaddr),
    .rdstb           (rdstb),
    .wrstb           (wrstb),
    .pass_thru       (pass_thru),
    .pass_thru_reset (pass_thru_reset)
  );

  logic [DW-1:0] rf        [0:(1<<AW)-1];
  logic [DW-1:0] model_mem [0:(1<<AW)-1];

  logic [AW-1:0] exp_wa [$];
  logic [DW-1:0] exp_wd [$];
  logic [AW-1:0] exp_ra [$];
  logic          exp_sdo[$];

  int n_checks = 0;
  int n_errors = 0;

  assign idata = rf[oaddr];

  initial begin
    SCK = 1'b0;
    forever #10 SCK = ~SCK;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor samples 2 ns before each rising edge, when both edge domains are settled.
  logic [AW-1:0] m_a;
  logic [DW-1:0] m_d;
  logic          m_b;
  always @(negedge SCK) begin
    #8;
    if (wrstb) begin
      if (exp_wa.size() == 0) begin
        check("wrstb_unexpected", 1, 0);
      end else begin
        m_a = exp_wa.pop_front();
        m_d = exp_wd.pop_front();
        check("wr_addr", oaddr, m_a);
        check("wr_data", odata, m_d);
      end
      rf[oaddr] = odata;
    end
    if (rdstb) begin
      if (exp_ra.size() == 0) begin
        check("rdstb_unexpected", 1, 0);
      end else begin
        m_a = exp_ra.pop_front();
        check("rd_addr", oaddr, m_a);
      end
    end
    if (!sdoenb && exp_sdo.size() > 0) begin
      m_b = exp_sdo.pop_front();
      check("sdo_bit", SDO, m_b);
    end
  end

  task automatic send_bit(input logic b);
    @(negedge SCK);
    #1;
    SDI = b;
  endtask

  task automatic check_reset_outputs();
    check("rst_sdo", SDO, 0);
    check("rst_sdoenb", sdoenb, 1);
    check("rst_rdstb", rdstb, 0);
    check("rst_wrstb", wrstb, 0);
    check("rst_pass_thru", pass_thru, 0);
    check("rst_pass_thru_reset", pass_thru_reset, 0);
    check("rst_oaddr", oaddr, 0);
    check("rst_predata", odata >> 1, 0);
  endtask

  task automatic end_txn();
    @(negedge SCK);
    #1;
    csb_reset = 1'b1;
    #2;
    check_reset_outputs();
    check("pending_writes", exp_wa.size(), 0);
    check("pending_reads", exp_ra.size(), 0);
    check("pending_sdo", exp_sdo.size(), 0);
    exp_wa.delete();
    exp_wd.delete();
    exp_ra.delete();
    exp_sdo.delete();
    @(posedge SCK);
    #2;
    csb_reset = 1'b0;
  endtask

  // One CSB-framed transaction; nstream/tail only apply when nnn=0.
  task automatic run_txn(input logic [7:0] cmd, input logic [AW-1:0] addr,
                         input logic [DW-1:0] d0, input int nstream, input int tail);
    logic             wr;
    logic             rd;
    int               nnn;
    int               ps;
    int               nw;
    logic [NPASS-1:0] mask;
    logic [AW-1:0]    a;
    logic [DW-1:0]    d;
    logic [DW-1:0]    dat[$];
    wr   = cmd[7];
    rd   = cmd[6];
    nnn  = int'(cmd[5:3]);
    ps   = int'(cmd[2:0]);
    mask = '0;
    if (ps >= 1 && ps <= NPASS) mask[ps-1] = 1'b1;
    nw = (nnn == 0) ? nstream : nnn;

    if (mask == '0) begin
      a = addr;
      if (rd) exp_ra.push_back(a);
      for (int k = 0; k < nw; k++) begin
        d = (k == 0) ? d0 : DW'($urandom);
        dat.push_back(d);
        if (rd) begin
          for (int i = DW - 1; i >= 0; i--) exp_sdo.push_back(model_mem[a][i]);
        end
        if (wr) begin
          exp_wa.push_back(a);
          exp_wd.push_back(d);
          model_mem[a] = d;
        end
        if (nnn == 0 || k < nnn - 1) a = a + 1'b1;
        if (rd) exp_ra.push_back(a);
      end
    end

    for (int i = 7; i >= 0; i--) send_bit(cmd[i]);
    @(posedge SCK);
    #2;
    check("ptr_after_cmd", pass_thru_reset, mask);
    check("pt_after_cmd", pass_thru, 0);

    if (mask != '0) begin
      send_bit(1'($urandom));
      @(posedge SCK);
      #2;
      check("pt_in_pass", pass_thru, mask);
      @(negedge SCK);
      #2;
      check("sdoenb_in_pass", sdoenb, 0);
      repeat (4) send_bit(1'($urandom));
      check("ptr_hold_pass", pass_thru_reset, mask);
    end else begin
      for (int i = AW - 1; i >= 0; i--) begin
        send_bit(addr[i]);
        if (i == AW - 1) begin
          @(posedge SCK);
          #2;
          check("pt_normal", pass_thru, 0);
        end
      end
      for (int k = 0; k < nw; k++) begin
        for (int i = DW - 1; i >= 0; i--) send_bit(dat[k][i]);
      end
      if (nnn == 0) repeat (tail) send_bit(1'($urandom));
      if (nnn != 0 || tail == 0) send_bit(1'b0);
    end
    end_txn();
  endtask

  initial begin
    logic [7:0]    cmd;
    logic [AW-1:0] ad;
    int            ns;
    int            tl;
    for (int i = 0; i < (1 << AW); i++) begin
      rf[i]        = DW'($urandom);
      model_mem[i] = rf[i];
    end
    SDI       = 1'b0;
    csb_reset = 1'b0;
    #1;
    csb_reset = 1'b1;
    #4;
    check_reset_outputs();
    @(posedge SCK);
    #2;
    csb_reset = 1'b0;

    run_txn(8'h88, 8'h10, 16'h00A5, 0, 0);
    rf[8'hFF] = 16'h1234; model_mem[8'hFF] = 16'h1234;
    rf[8'h00] = 16'hBEEF; model_mem[8'h00] = 16'hBEEF;
    run_txn(8'h50, 8'hFF, 16'h0000, 0, 0);
    run_txn(8'hC2, 8'h00, 16'h0000, 0, 0);
    run_txn(8'h4D, 8'h33, 16'h0000, 0, 0);
    run_txn(8'h80, 8'h40, 16'h5A5A, 3, 5);
    run_txn(8'hC8, 8'h21, 16'hC0DE, 0, 0);
    run_txn(8'h00, 8'h77, 16'hFFFF, 2, 0);

    for (int t = 0; t < 40; t++) begin
      cmd = 8'($urandom);
      ad  = AW'($urandom);
      ns  = $urandom_range(1, 3);
      tl  = $urandom_range(0, DW - 2);
      run_txn(cmd, ad, DW'($urandom), ns, tl);
    end

    #50;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
